rca_lsq: RTL and testbench
==========================

// Module: rca_lsq
// PURPOSE
//  In-order load/store queue directly downstream of the RCA PR modules' LSQ port. Buffers
//  requests (addr/data/fn3/load/store) from one PR slot, issues them one at a time to the RCA
//  memory port, formats load data per fn3 and returns it on load_data/load_complete. Asserts
//  lsq_full as back-pressure to the requesting PR module.
// PARAMETERS
//  DEPTH  4  queue entries (power of two, >=2)
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous active-high reset
//  addr           in   XLEN  request byte address from PR module
//  data           in   XLEN  store data (unaligned, in low bits)
//  fn3            in   3     RISC-V funct3: LB/LH/LW/LBU/LHU or SB/SH/SW
//  load           in   1     request is a load
//  store          in   1     request is a store
//  new_request    in   1     enqueue strobe
//  lsq_full       out  1     queue full; new_request ignored while high
//  load_data      out  XLEN  formatted load result
//  load_complete  out  1     one-cycle pulse, load_data valid
//  mem_req        out  1     memory request valid
//  mem_addr       out  XLEN  byte address, forwarded unmodified
//  mem_we         out  1     1 = store
//  mem_be         out  4     byte enables
//  mem_wdata      out  XLEN  lane-aligned store data
//  mem_ack        in   1     request accepted this cycle (mem_req & mem_ack = handshake)
//  mem_rvalid     in   1     load response valid, >=1 cycle after ack
//  mem_rdata      in   XLEN  raw 32-bit word
// BEHAVIOUR
//  Reset: queue empty, FSM=REQ, lsq_full=0, load_complete=0, load_data=0, mem_req=0.
//  Enqueue: new_request & !lsq_full & (load^store) writes {addr,data,fn3,is_store} at tail.
//   load==store (both/neither) -> ignored. new_request while full -> dropped, no state change.
//  lsq_full = (count==DEPTH), from registered count; enqueue blocked when full even if a pop
//   occurs same cycle. Simultaneous push+pop when not full: count unchanged.
//  FSM REQ: mem_req = !empty, driven from head entry. Earliest mem_req: cycle after enqueue.
//   mem_ack & store -> pop, stay REQ (next entry may issue next cycle).
//   mem_ack & load  -> WAIT_LOAD, head retained. mem_ack with mem_req=0 ignored.
//  FSM WAIT_LOAD: mem_req=0. On mem_rvalid: pop head, load_data/load_complete registered
//   (valid cycle after mem_rvalid, one-cycle pulse), -> REQ. mem_rvalid outside WAIT ignored.
//  Byte lane select: byte uses addr[1:0], half uses addr[1] (addr[0] ignored), word ignores
//   addr[1:0]. mem_be: SB/LB/LBU 0001<<lane; SH/LH/LHU 0011<<(2*addr[1]); word 1111.
//  mem_wdata: byte replicated x4, half replicated x2, word as-is.
//  Load format: extract lane from mem_rdata; LB/LH sign-extend, LBU/LHU zero-extend to XLEN.
//  Undefined fn3 (011,110,111): treated as word access.
//  Head pointer wraps modulo DEPTH; count width clog2(DEPTH)+1.
//  rst mid-operation: queue flushed, in-flight request abandoned; next-cycle state = reset.
// STRUCTURE
//  rca_config: lsq_entry_t {addr, data, fn3, is_store}; LSQ_DEPTH default; fn3 constants
//   (LS_B=000, LS_H=001, LS_W=010, LS_BU=100, LS_HU=101).
//  Sub-module rca_lsq_fifo: DEPTH-entry FIFO of lsq_entry_t, push/pop/full/empty/count.
//  FSM, lane/byte-enable generation and load formatter stay in rca_lsq.
// TESTING
//  SW addr=0x100 data=0xDEADBEEF, ack same cycle -> mem_we=1 be=1111 wdata=0xDEADBEEF, popped.
//  SB addr=0x103 data=0x5A -> be=1000, wdata=0x5A5A5A5A.
//  LB addr=0x102, rdata=0x00800000 -> load_data=0xFFFFFF80; LBU same -> 0x00000080, pulse 1 cyc.
//  Enqueue 4 loads, hold mem_ack=0 -> lsq_full=1; 5th request dropped; drain -> 4 completions in order.
//  LH addr=0x102 + SW enqueued same time as pop at count=3 -> count stays 3, both ordered.
//  rst asserted during WAIT_LOAD, mem_rvalid next cycle -> no load_complete, queue empty.

Source files
------------

// File: rtl/rca_config.sv
// Shared types and constants for the RCA load/store path: queue entry layout,
// funct3 encodings and the access-size decode used by the LSQ.
package rca_config;

   localparam int XLEN      = 32;
   localparam int LSQ_DEPTH = 4;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
      logic [2:0]      fn3;
      logic            is_store;
   } lsq_entry_t;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

   typedef enum logic {ST_REQ, ST_WAIT_LOAD} lsq_state_e;

   // Unused funct3 codes fall through to a full-word access.
   function automatic acc_size_e decode_size(input logic [2:0] f);
      case (f)
         LS_B, LS_BU: return SZ_B;
         LS_H, LS_HU: return SZ_H;
         LS_W:        return SZ_W;
         default:     return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/rca_lsq_fifo.sv
// DEPTH-entry circular FIFO of LSQ entries with registered occupancy count.
module rca_lsq_fifo
   import rca_config::*;
#(
   parameter int DEPTH = LSQ_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  lsq_entry_t    din,
   input  logic          pop,
   output lsq_entry_t    dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   lsq_entry_t    mem_q [DEPTH];
   logic [AW-1:0] head_q, tail_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[head_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) tail_q <= tail_q + 1'b1;
         if (do_pop)  head_q <= head_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; count_q alone says which slots hold live data.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q] <= din;
   end

endmodule

// File: rtl/rca_lsq.sv
// In-order load/store queue between a PR slot and the RCA memory port: issues one
// request at a time, aligns store lanes and formats returned load data.
module rca_lsq
   import rca_config::*;
#(
   parameter int DEPTH = LSQ_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] data,
   input  logic [2:0]      fn3,
   input  logic            load,
   input  logic            store,
   input  logic            new_request,
   output logic            lsq_full,
   output logic [XLEN-1:0] load_data,
   output logic            load_complete,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   output logic            mem_we,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int CW = $clog2(DEPTH) + 1;

   lsq_state_e      state_q, state_d;
   lsq_entry_t      head, new_entry;
   logic            fifo_full, fifo_empty, push, pop;
   logic [CW-1:0]   fifo_count;
   logic [XLEN-1:0] load_data_q, load_data_d, load_fmt, shifted;
   logic            load_complete_q, load_complete_d, sign_ext;
   acc_size_e       head_size;
   logic [1:0]      lane;

   assign new_entry = '{addr: addr, data: data, fn3: fn3, is_store: store};
   assign push      = new_request & ~fifo_full & (load ^ store);
   assign lsq_full  = (fifo_count == CW'(DEPTH));

   rca_lsq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (new_entry),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head_size = decode_size(head.fn3);
   assign sign_ext  = ~head.fn3[2];
   assign mem_addr  = head.addr;
   assign mem_we    = head.is_store;
   assign shifted   = mem_rdata >> {lane, 3'b000};

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      lane      = 2'b00;
      mem_be    = 4'b1111;
      mem_wdata = head.data;
      load_fmt  = shifted;
      case (head_size)
         SZ_B: begin
            lane      = head.addr[1:0];
            mem_be    = 4'b0001 << lane;
            mem_wdata = {4{head.data[7:0]}};
            load_fmt  = {{(XLEN-8){sign_ext & shifted[7]}}, shifted[7:0]};
         end
         SZ_H: begin
            lane      = {head.addr[1], 1'b0};
            mem_be    = 4'b0011 << lane;
            mem_wdata = {2{head.data[15:0]}};
            load_fmt  = {{(XLEN-16){sign_ext & shifted[15]}}, shifted[15:0]};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      mem_req         = 1'b0;
      pop             = 1'b0;
      load_complete_d = 1'b0;
      load_data_d     = load_data_q;
      case (state_q)
         ST_REQ: begin
            mem_req = ~fifo_empty;
            if (mem_req && mem_ack) begin
               if (head.is_store) pop     = 1'b1;
               else               state_d = ST_WAIT_LOAD;
            end
         end
         ST_WAIT_LOAD: begin
            if (mem_rvalid) begin
               pop             = 1'b1;
               load_complete_d = 1'b1;
               load_data_d     = load_fmt;
               state_d         = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_REQ;
         load_data_q     <= '0;
         load_complete_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         load_data_q     <= load_data_d;
         load_complete_q <= load_complete_d;
      end
   end

   assign load_data     = load_data_q;
   assign load_complete = load_complete_q;

endmodule

// File: tb/tb_rca_lsq.sv
// Self-checking bench for rca_lsq: directed scenarios plus random traffic, all
// compared against a queue-based reference model of the load/store queue.
module tb_rca_lsq;
   import rca_config::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, data, mem_rdata;
   logic [2:0]  fn3;
   logic        load, store, new_request, mem_ack, mem_rvalid;
   logic        lsq_full, load_complete, mem_req, mem_we;
   logic [31:0] load_data, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   always #5 clk = ~clk;

   rca_lsq #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .fn3(fn3),
      .load(load), .store(store), .new_request(new_request),
      .lsq_full(lsq_full), .load_data(load_data), .load_complete(load_complete),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f;
      bit          st;
   } req_t;

   req_t        mq[$];
   bit          waiting;
   bit          exp_lc;
   logic [31:0] exp_ld;
   int          n_assert = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int sz(input logic [2:0] f);
      if (f == 3'b000 || f == 3'b100) return 1;
      if (f == 3'b001 || f == 3'b101) return 2;
      return 4;
   endfunction

   function automatic int off(input req_t r);
      int n = sz(r.f);
      return (int'(r.a[1:0]) / n) * n;
   endfunction

   function automatic logic [31:0] mask(input int n);
      return (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
   endfunction

   function automatic logic [3:0] exp_be(input req_t r);
      int bits = (1 << sz(r.f)) - 1;
      return 4'(bits << off(r));
   endfunction

   function automatic logic [31:0] exp_wdata(input req_t r);
      logic [31:0] v = '0;
      int n = sz(r.f);
      for (int i = 0; i < 4 / n; i++) v |= (r.d & mask(n)) << (8 * n * i);
      return v;
   endfunction

   function automatic logic [31:0] exp_load(input req_t r, input logic [31:0] rd);
      int n = sz(r.f);
      logic [31:0] v = (rd >> (8 * off(r))) & mask(n);
      if (n < 4 && !r.f[2] && v[8*n-1]) v = v - (32'd1 << (8 * n));
      return v;
   endfunction

   // One clock: drive inputs, compare outputs with the model, then advance both.
   task automatic cyc(input bit nr, input bit ld, input bit st, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] f, input bit ack,
                      input bit rv, input logic [31:0] rd);
      bit er, push_ok, nlc;
      new_request = nr; load = ld; store = st; addr = a; data = d; fn3 = f;
      mem_ack = ack; mem_rvalid = rv; mem_rdata = rd;
      #2;
      er = !waiting && mq.size() > 0;
      check("mem_req", mem_req, er);
      check("lsq_full", lsq_full, mq.size() == DEPTH);
      check("load_complete", load_complete, exp_lc);
      check("load_data", load_data, exp_ld);
      if (er) begin
         check("mem_addr", mem_addr, mq[0].a);
         check("mem_we", mem_we, mq[0].st);
         check("mem_be", mem_be, exp_be(mq[0]));
         if (mq[0].st) check("mem_wdata", mem_wdata, exp_wdata(mq[0]));
      end
      push_ok = nr && (ld ^ st) && mq.size() < DEPTH;
      nlc = 1'b0;
      if (er && ack) begin
         if (mq[0].st) void'(mq.pop_front());
         else          waiting = 1'b1;
      end else if (waiting && rv) begin
         nlc = 1'b1;
         exp_ld = exp_load(mq[0], rd);
         void'(mq.pop_front());
         waiting = 1'b0;
      end
      if (push_ok) mq.push_back('{a, d, f, st});
      @(posedge clk);
      #1;
      exp_lc = nlc;
   endtask

   task automatic enq(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f);
      cyc(1'b1, ld, st, a, d, f, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic ack_cyc();
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 1'b0, 32'h0);
   endtask

   task automatic resp(input logic [31:0] rd);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, rd);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1; new_request = 1'b0; load = 1'b0; store = 1'b0; addr = '0; data = '0;
      fn3 = '0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      waiting = 1'b0;
      exp_lc = 1'b0;
      exp_ld = '0;
   endtask

   initial begin
      rst = 1'b1;
      do_reset();
      idle();

      // Word store, accepted on its first request cycle.
      enq(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, LS_W);
      check("sw_be", mem_be, 4'hF);
      check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("sw_we", mem_we, 1'b1);
      ack_cyc();
      check("sw_popped", mem_req, 1'b0);

      // Byte store at lane 3.
      enq(1'b0, 1'b1, 32'h103, 32'h0000_005A, LS_B);
      check("sb_be", mem_be, 4'b1000);
      check("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
      ack_cyc();

      // Signed and unsigned byte loads from lane 2.
      enq(1'b1, 1'b0, 32'h102, 32'h0, LS_B);
      ack_cyc();
      resp(32'h0080_0000);
      check("lb_data", load_data, 32'hFFFF_FF80);
      check("lb_pulse", load_complete, 1'b1);
      idle();
      check("lb_pulse_end", load_complete, 1'b0);
      enq(1'b1, 1'b0, 32'h102, 32'h0, LS_BU);
      ack_cyc();
      resp(32'h0080_0000);
      check("lbu_data", load_data, 32'h0000_0080);
      idle();

      // Fill with loads, drop a fifth request, drain in order.
      for (int i = 0; i < 4; i++) enq(1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'h0, LS_W);
      check("full_after_4", lsq_full, 1'b1);
      enq(1'b1, 1'b0, 32'h300, 32'h0, LS_W);
      check("full_after_drop", lsq_full, 1'b1);
      for (int i = 0; i < 4; i++) begin
         ack_cyc();
         resp(32'h1111_0000 + 32'(i));
         check("drain_order", load_data, 32'h1111_0000 + 32'(i));
      end
      idle();

      // Push and pop in the same cycle at count 3.
      enq(1'b1, 1'b0, 32'h102, 32'h0, LS_H);
      enq(1'b0, 1'b1, 32'h400, 32'h1, LS_W);
      enq(1'b0, 1'b1, 32'h404, 32'h2, LS_W);
      ack_cyc();
      cyc(1'b1, 1'b0, 1'b1, 32'h408, 32'h3, LS_W, 1'b0, 1'b1, 32'h8000_1234);
      check("lh_data", load_data, 32'hFFFF_8000);
      check("count3_not_full", lsq_full, 1'b0);
      enq(1'b0, 1'b1, 32'h40C, 32'h4, LS_W);
      check("count4_full", lsq_full, 1'b1);
      // Enqueue attempted while full with a pop in the same cycle: still dropped.
      cyc(1'b1, 1'b0, 1'b1, 32'h500, 32'h5, LS_W, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) ack_cyc();
      idle();
      check("drained_empty", mem_req, 1'b0);

      // Requests with load==store are ignored.
      enq(1'b1, 1'b1, 32'h600, 32'h0, LS_W);
      enq(1'b0, 1'b0, 32'h604, 32'h0, LS_W);
      idle();
      check("invalid_ignored", mem_req, 1'b0);

      // Reset while waiting on a load abandons it.
      enq(1'b1, 1'b0, 32'h700, 32'h0, LS_W);
      ack_cyc();
      do_reset();
      resp(32'hCAFE_F00D);
      check("rst_no_complete", load_complete, 1'b0);
      check("rst_empty", mem_req, 1'b0);
      check("rst_load_data", load_data, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [1:0] ls;
         ls = 2'($urandom_range(0, 3));
         cyc(bit'($urandom_range(0, 1)), ls[0], ls[1], $urandom, $urandom,
             3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
             bit'($urandom_range(0, 1)), $urandom);
      end
      for (int i = 0; i < 24; i++)
         cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 1'b1, $urandom);
      idle();
      check("final_empty", mem_req, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
